clint: RTL and testbench



---
 rtl/clint.sv | 155 +++++++++++++++
 tb/tb_clint.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clint.sv
`default_nettype none
// ============================================================================
// Module   : clint
// Brief    : Core-local trap controller; detects ECALL/EBREAK/MRET and external
//            interrupts, then sequences the mepc/mcause/mstatus writes.
// Revision : 1.0 - initial release
// ============================================================================
module clint #(
    parameter logic [31:0] ECALL_CAUSE   = 32'd11,
    parameter logic [31:0] EBREAK_CAUSE  = 32'd3,
    parameter logic [31:0] EXT_INT_CAUSE = 32'h8000_000B
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst_i,
    input  logic [31:0] inst_addr_i,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_flag_i,
    input  logic [7:0]  int_flag_i,
    input  logic [31:0] csr_mtvec,
    input  logic [31:0] csr_mepc,
    input  logic [31:0] csr_mstatus,
    output logic        hold_flag_o,
    output logic        we_o,
    output logic [31:0] waddr_o,
    output logic [31:0] data_o,
    output logic        int_assert_o,
    output logic [31:0] int_addr_o
);

    localparam logic [31:0] c_INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] c_INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] c_INST_MRET   = 32'h3020_0073;
    localparam logic [31:0] c_CSR_MSTATUS = 32'h0000_0300;
    localparam logic [31:0] c_CSR_MEPC    = 32'h0000_0341;
    localparam logic [31:0] c_CSR_MCAUSE  = 32'h0000_0342;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_MEPC    = 3'd1,
        S_MCAUSE  = 3'd2,
        S_MSTATUS = 3'd3,
        S_MRET    = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_epc;
    logic [31:0] r_cause;
    logic [31:0] w_epc_next;
    logic [31:0] w_cause_next;
    logic        w_capture;
    logic        w_idle;
    logic        w_is_ecall;
    logic        w_is_ebreak;
    logic        w_is_mret;
    logic        w_async;
    logic        w_event;

    // Detection is qualified by rst_n so hold_flag_o is also forced low in reset
    assign w_idle      = (r_state == S_IDLE) && rst_n;
    assign w_is_ecall  = (inst_i == c_INST_ECALL);
    assign w_is_ebreak = (inst_i == c_INST_EBREAK);
    assign w_is_mret   = (inst_i == c_INST_MRET);
    assign w_async     = (int_flag_i != 8'd0) && csr_mstatus[3] && !hold_flag_i;
    assign w_event     = w_idle && (w_is_ecall || w_is_ebreak || w_is_mret || w_async);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_epc   <= 32'd0;
            r_cause <= 32'd0;
        end else begin
            r_state <= w_next_state;
            if (w_capture) begin
                r_epc   <= w_epc_next;
                r_cause <= w_cause_next;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_epc_next   = inst_addr_i;
        w_cause_next = ECALL_CAUSE;
        case (r_state)
            S_IDLE: begin
                if (w_is_ecall || w_is_ebreak) begin
                    w_next_state = S_MEPC;
                    w_capture    = 1'b1;
                    w_cause_next = w_is_ecall ? ECALL_CAUSE : EBREAK_CAUSE;
                end else if (w_is_mret) begin
                    w_next_state = S_MRET;
                end else if (w_async) begin
                    // A redirecting instruction has retired; resume at its target
                    w_next_state = S_MEPC;
                    w_capture    = 1'b1;
                    w_epc_next   = jump_en_i ? jump_addr_i : inst_addr_i;
                    w_cause_next = EXT_INT_CAUSE;
                end
            end
            S_MEPC:    w_next_state = S_MCAUSE;
            S_MCAUSE:  w_next_state = S_MSTATUS;
            S_MSTATUS: w_next_state = S_IDLE;
            S_MRET:    w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        hold_flag_o  = w_event;
        we_o         = 1'b0;
        waddr_o      = 32'd0;
        data_o       = 32'd0;
        int_assert_o = 1'b0;
        int_addr_o   = 32'd0;
        case (r_state)
            S_MEPC: begin
                hold_flag_o = 1'b1;
                we_o        = 1'b1;
                waddr_o     = c_CSR_MEPC;
                data_o      = r_epc;
            end
            S_MCAUSE: begin
                hold_flag_o = 1'b1;
                we_o        = 1'b1;
                waddr_o     = c_CSR_MCAUSE;
                data_o      = r_cause;
            end
            S_MSTATUS: begin
                hold_flag_o  = 1'b1;
                we_o         = 1'b1;
                waddr_o      = c_CSR_MSTATUS;
                data_o       = {csr_mstatus[31:8], csr_mstatus[3], csr_mstatus[6:4],
                                1'b0, csr_mstatus[2:0]};
                int_assert_o = 1'b1;
                int_addr_o   = csr_mtvec;
            end
            S_MRET: begin
                hold_flag_o  = 1'b1;
                we_o         = 1'b1;
                waddr_o      = c_CSR_MSTATUS;
                data_o       = {csr_mstatus[31:8], 1'b1, csr_mstatus[6:4],
                                csr_mstatus[7], csr_mstatus[2:0]};
                int_assert_o = 1'b1;
                int_addr_o   = csr_mepc;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_clint.sv
`default_nettype none
// ============================================================================
// Module   : tb_clint
// Brief    : Scoreboard bench for clint; expected CSR writes and redirects are
//            queued with each stimulus and popped as the DUT produces them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clint;

    localparam logic [31:0] c_NOP    = 32'h0000_0013;
    localparam logic [31:0] c_ECALL  = 32'h0000_0073;
    localparam logic [31:0] c_EBREAK = 32'h0010_0073;
    localparam logic [31:0] c_MRET   = 32'h3020_0073;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] inst_i, inst_addr_i, jump_addr_i;
    logic        jump_en_i, hold_flag_i;
    logic [7:0]  int_flag_i;
    logic [31:0] csr_mtvec, csr_mepc, csr_mstatus;
    logic        hold_flag_o, we_o, int_assert_o;
    logic [31:0] waddr_o, data_o, int_addr_o;

    int          checks   = 0;
    int          failures = 0;
    logic [63:0] exp_wr[$];
    logic [31:0] exp_redir[$];

    clint dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .inst_i       (inst_i),
        .inst_addr_i  (inst_addr_i),
        .jump_en_i    (jump_en_i),
        .jump_addr_i  (jump_addr_i),
        .hold_flag_i  (hold_flag_i),
        .int_flag_i   (int_flag_i),
        .csr_mtvec    (csr_mtvec),
        .csr_mepc     (csr_mepc),
        .csr_mstatus  (csr_mstatus),
        .hold_flag_o  (hold_flag_o),
        .we_o         (we_o),
        .waddr_o      (waddr_o),
        .data_o       (data_o),
        .int_assert_o (int_assert_o),
        .int_addr_o   (int_addr_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] trap_mstatus(input logic [31:0] m);
        logic [31:0] r;
        r    = m & ~32'h0000_0088;
        r[7] = m[3];
        return r;
    endfunction

    function automatic logic [31:0] mret_mstatus(input logic [31:0] m);
        logic [31:0] r;
        r    = m & ~32'h0000_0088;
        r[7] = 1'b1;
        r[3] = m[7];
        return r;
    endfunction

    task automatic push_trap(input logic [31:0] epc, input logic [31:0] cause);
        exp_wr.push_back({32'h341, epc});
        exp_wr.push_back({32'h342, cause});
        exp_wr.push_back({32'h300, trap_mstatus(csr_mstatus)});
        exp_redir.push_back(csr_mtvec);
    endtask

    // Call at a negedge right after driving the inputs. Cycle 0 is the
    // detection cycle; the mstatus write is folded into the bench CSR copy
    // and the pipeline is flushed to NOP on each redirect.
    task automatic run_seq(input int budget, output int holds, output int assert_at);
        logic [63:0] e;
        logic [31:0] r;
        holds     = 0;
        assert_at = -1;
        for (int i = 0; i < budget; i++) begin
            if (i == 0) #1;
            else @(negedge clk);
            if (hold_flag_o) holds++;
            if (we_o) begin
                if (exp_wr.size() == 0) begin
                    check("spurious_we", {31'd0, we_o}, 32'd0);
                end else begin
                    e = exp_wr.pop_front();
                    check("waddr", waddr_o, e[63:32]);
                    check("wdata", data_o, e[31:0]);
                    if (e[63:32] == 32'h300) csr_mstatus = e[31:0];
                end
            end
            if (int_assert_o) begin
                assert_at = i;
                if (exp_redir.size() == 0) begin
                    check("spurious_int_assert", {31'd0, int_assert_o}, 32'd0);
                end else begin
                    r = exp_redir.pop_front();
                    check("int_addr", int_addr_o, r);
                end
                inst_i    = c_NOP;
                jump_en_i = 1'b0;
            end
            if (!hold_flag_o && i > 0) break;
        end
        check("wr_queue_drained", exp_wr.size(), 32'd0);
        check("redir_queue_drained", exp_redir.size(), 32'd0);
        exp_wr.delete();
        exp_redir.delete();
    endtask

    int holds, at;

    initial begin
        rst_n       = 1'b0;
        inst_i      = c_NOP;
        inst_addr_i = 32'h0000_00F0;
        jump_en_i   = 1'b0;
        jump_addr_i = 32'd0;
        hold_flag_i = 1'b0;
        int_flag_i  = 8'd0;
        csr_mtvec   = 32'h0000_0400;
        csr_mepc    = 32'd0;
        csr_mstatus = 32'h0000_0008;

        #1;
        check("rst_hold", {31'd0, hold_flag_o}, 32'd0);
        check("rst_we", {31'd0, we_o}, 32'd0);
        check("rst_int_assert", {31'd0, int_assert_o}, 32'd0);
        check("rst_data", data_o, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // ECALL
        inst_i      = c_ECALL;
        inst_addr_i = 32'h0000_0100;
        push_trap(32'h0000_0100, 32'd11);
        run_seq(10, holds, at);
        check("ecall_hold_cycles", holds, 32'd4);
        check("ecall_assert_cycle", at, 32'd3);
        check("ecall_mstatus_after", csr_mstatus, 32'h0000_0080);

        // External IRQ with a redirect in flight
        @(negedge clk);
        csr_mstatus = 32'h0000_0008;
        inst_addr_i = 32'h0000_01F0;
        int_flag_i  = 8'h01;
        jump_en_i   = 1'b1;
        jump_addr_i = 32'h0000_0200;
        push_trap(32'h0000_0200, 32'h8000_000B);
        run_seq(10, holds, at);
        check("irq_hold_cycles", holds, 32'd4);
        check("irq_assert_cycle", at, 32'd3);

        // Same IRQ with MIE now clear: nothing happens
        @(negedge clk);
        int_flag_i = 8'h01;
        run_seq(4, holds, at);
        check("irq_masked_hold", holds, 32'd0);
        check("irq_masked_assert", at, -32'sd1);
        int_flag_i = 8'h00;

        // MRET
        @(negedge clk);
        csr_mstatus = 32'h0000_0080;
        csr_mepc    = 32'h0000_0104;
        inst_i      = c_MRET;
        exp_wr.push_back({32'h300, mret_mstatus(csr_mstatus)});
        exp_redir.push_back(32'h0000_0104);
        run_seq(10, holds, at);
        check("mret_hold_cycles", holds, 32'd2);
        check("mret_assert_cycle", at, 32'd1);
        check("mret_mstatus_after", csr_mstatus, 32'h0000_0088);

        // EBREAK with a coincident IRQ: EBREAK wins, IRQ left pending
        @(negedge clk);
        csr_mstatus = 32'h0000_0008;
        inst_i      = c_EBREAK;
        inst_addr_i = 32'h0000_0120;
        int_flag_i  = 8'h01;
        push_trap(32'h0000_0120, 32'd3);
        run_seq(10, holds, at);
        check("prio_ebreak_hold", holds, 32'd4);

        // Re-enable MIE: pending IRQ is taken
        @(negedge clk);
        csr_mstatus = 32'h0000_0008;
        inst_addr_i = 32'h0000_0124;
        push_trap(32'h0000_0124, 32'h8000_000B);
        run_seq(10, holds, at);
        check("prio_irq_hold", holds, 32'd4);
        int_flag_i = 8'h00;

        // IRQ blocked while the pipeline is held elsewhere
        @(negedge clk);
        csr_mstatus = 32'h0000_0008;
        int_flag_i  = 8'h80;
        hold_flag_i = 1'b1;
        inst_addr_i = 32'h0000_0130;
        run_seq(4, holds, at);
        check("held_irq_hold", holds, 32'd0);
        hold_flag_i = 1'b0;
        push_trap(32'h0000_0130, 32'h8000_000B);
        run_seq(10, holds, at);
        check("released_irq_hold", holds, 32'd4);
        check("released_irq_assert", at, 32'd3);
        int_flag_i = 8'h00;

        // Reset asserted during MCAUSE
        @(negedge clk);
        csr_mstatus = 32'h0000_0008;
        inst_i      = c_ECALL;
        inst_addr_i = 32'h0000_0140;
        #1;
        check("rstmid_detect_hold", {31'd0, hold_flag_o}, 32'd1);
        @(negedge clk);
        check("rstmid_mepc_addr", waddr_o, 32'h341);
        @(negedge clk);
        check("rstmid_mcause_addr", waddr_o, 32'h342);
        check("rstmid_mcause_data", data_o, 32'd11);
        #2;
        rst_n  = 1'b0;
        inst_i = c_NOP;
        #1;
        check("rstmid_we", {31'd0, we_o}, 32'd0);
        check("rstmid_waddr", waddr_o, 32'd0);
        check("rstmid_data", data_o, 32'd0);
        check("rstmid_int_assert", {31'd0, int_assert_o}, 32'd0);
        check("rstmid_int_addr", int_addr_o, 32'd0);
        check("rstmid_hold", {31'd0, hold_flag_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_seq(6, holds, at);
        check("post_rst_hold", holds, 32'd0);
        check("post_rst_assert", at, -32'sd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
